rtc_lector_secuencia: RTL and testbench
=======================================

Name: rtc_lector_secuencia

Overview:
- Bus master that reads the time-of-day and timer registers from the external RTC over its multiplexed address/data bus.
- Converts each BCD register value to binary and streams the bytes, one at a time, to the display interface.
- Output is the byte stream (datoRTC with inicioSecuencia framing) that the VGA interface consumes once per screen refresh.
- Sits between the RTC pins and the display interface; launched once per frame by the refresh tick.

Parameters:
- T_FASE, 4, clk cycles each bus strobe (wr_n or rd_n) stays low; legal range 1..15.
- DIR_BASE_RELOJ, 8'h21, RTC address of seconds; clock registers occupy DIR_BASE_RELOJ..DIR_BASE_RELOJ+7.
- DIR_BASE_TEMP, 8'h41, RTC address of timer seconds; timer registers occupy DIR_BASE_TEMP..DIR_BASE_TEMP+2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  single-cycle start pulse (refresh tick).
- temporizador  in  1  high = also read the 3 timer registers.
- ad_in  in  8  RTC bus value sampled during read.
- ad_out  out  8  address driven onto RTC bus.
- ad_oe  out  1  tri-state enable for ad_out.
- a_d  out  1  0 = address phase, 1 = data phase.
- cs_n  out  1  RTC chip select, active-low.
- wr_n  out  1  address strobe, active-low.
- rd_n  out  1  read strobe, active-low.
- datoRTC  out  8  binary value of the register just read.
- datoValido  out  1  one-cycle qualifier for datoRTC.
- inicioSecuencia  out  1  one-cycle, coincident with the first datoValido of a sequence.
- finSecuencia  out  1  one-cycle, coincident with the last datoValido of a sequence.
- ocupado  out  1  high from the cycle after iniciar is accepted until the cycle after finSecuencia.

Behaviour:
- Reset (async, while reset=0):
  - cs_n=wr_n=rd_n=1; ad_oe=0; a_d=0; ad_out=0.
  - datoRTC=0; datoValido=inicioSecuencia=finSecuencia=ocupado=0.
  - FSM to REPOSO; byte counter=0.
  - Reset mid-transaction aborts immediately; no partial byte is emitted after release.
- Sequence length N:
  - temporizador sampled only in the cycle iniciar is accepted, then latched for the whole sequence.
  - N=8 if latched value is 0; N=11 if 1.
- Read order: seconds, minutes, hours, date, month, year, day-of-week, week-number, then timer seconds, timer minutes, timer hours.
- Address for index i:
  - i<8: DIR_BASE_RELOJ+i.
  - i>=8: DIR_BASE_TEMP+(i-8).
- FSM states:
  - REPOSO: outputs idle. On iniciar=1: latch temporizador, index=0, go to ESC_DIR.
  - ESC_DIR: T_FASE cycles with cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=address. Then go to PAUSA1.
  - PAUSA1: 1 cycle with cs_n=1, wr_n=1, ad_oe=0. Then go to LEE.
  - LEE: T_FASE cycles with cs_n=0, rd_n=0, a_d=1, ad_oe=0. ad_in is registered on the last LEE cycle. Then go to EMITE.
  - EMITE: 1 cycle, datoValido=1, datoRTC=converted value. inicioSecuencia=1 if index=0; finSecuencia=1 if index=N-1. Then go to PAUSA2.
  - PAUSA2: 1 cycle with all strobes high. Increment index. Go to ESC_DIR if index<N, else REPOSO.
- Cost per byte: 2*T_FASE+3 cycles. A full sequence takes N*(2*T_FASE+3) cycles, with first datoValido at cycle 2*T_FASE+3 after acceptance.
- BCD conversion:
  - hi = ad_in[7:4], lo = ad_in[3:0].
  - For the hours register (index 2 and 10), hi is masked to ad_in[5:4] (24 h mode).
  - datoRTC = hi*10 + lo, computed in 8 bits (max 99).
  - If hi>9 or lo>9, datoRTC = 8'hFF, emitted with datoValido as normal; no abort.
- Boundaries:
  - iniciar while ocupado=1 is ignored; it is not queued.
  - iniciar in the same cycle as PAUSA2→REPOSO of the last byte is ignored; iniciar is accepted only in REPOSO.
  - wr_n and rd_n are never low simultaneously.
  - ad_oe=1 only while wr_n=0.
  - temporizador toggling mid-sequence has no effect until the next sequence.

Test Plan:
- T_FASE=2, temporizador=0, iniciar pulse, RTC model returns 8'h59 at 0x21 → 8 datoValido pulses spaced 7 cycles apart.
  - First datoRTC=59 with inicioSecuencia=1, at cycle 7 after acceptance.
  - finSecuencia on the 8th pulse; ocupado falls one cycle later.
- temporizador=1, timer hours register 0x43=8'h23 → 11 bytes.
  - 11th byte datoRTC=23 with finSecuencia=1.
  - Addresses observed on ad_out in order: 0x21..0x28, 0x41..0x43.
- Hours register = 8'hE7 (upper bits set) → datoRTC=27 (mask applied).
  - Date register = 8'h3A → datoRTC=8'hFF.
- Second iniciar pulse during byte 3 → ignored; total pulses remain 8.
  - Next iniciar after ocupado=0 starts a new sequence with inicioSecuencia.
- reset asserted during LEE of byte 5 → strobes high and ad_oe=0 asynchronously, no further datoValido.
  - After release and iniciar, the sequence restarts at address 0x21.
- Throughout all runs, check: wr_n/rd_n never both low; ad_oe only with wr_n=0; cs_n=1 in PAUSA states.

Source files
------------

// File: rtl/rtc_lector_secuencia_if.sv
// RTC multiplexed address/data pins plus the byte stream
// handed to the display side.
interface rtc_lector_secuencia_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] datoRTC;
    logic       datoValido;
    logic       inicioSecuencia;
    logic       finSecuencia;
    logic       ocupado;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, a_d, cs_n, wr_n, rd_n,
        output datoRTC, datoValido, inicioSecuencia,
        output finSecuencia, ocupado
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, a_d, cs_n, wr_n, rd_n,
        input  datoRTC, datoValido, inicioSecuencia,
        input  finSecuencia, ocupado
    );
endinterface

// File: rtl/rtc_lector_secuencia.sv
// Reads clock (and optionally timer) registers from the RTC bus,
// converts BCD to binary and streams one byte per register read.
module rtc_lector_secuencia #(
    parameter int         T_FASE         = 4,
    parameter logic [7:0] DIR_BASE_RELOJ = 8'h21,
    parameter logic [7:0] DIR_BASE_TEMP  = 8'h41
) (
    input  logic clk,
    input  logic reset,
    input  logic iniciar,
    input  logic temporizador,
    rtc_lector_secuencia_if.master rtc
);
    typedef enum logic [2:0] {
        REPOSO, ESC_DIR, PAUSA1, LEE, EMITE, PAUSA2
    } estado_t;

    estado_t    estado, estadoSig;
    logic [3:0] cnt;
    logic [3:0] indice;
    logic       conTemp;
    logic [7:0] lectura;
    logic       ultimaFase;
    logic       ultimoIndice;
    logic [7:0] dir;
    logic [3:0] hi, lo;
    logic [7:0] valor;

    assign ultimaFase   = (cnt == 4'(T_FASE - 1));
    assign ultimoIndice = (indice == (conTemp ? 4'd10 : 4'd7));

    always_comb begin
        dir = DIR_BASE_RELOJ + {4'd0, indice};
        if (indice >= 4'd8)
            dir = DIR_BASE_TEMP + {4'd0, indice - 4'd8};
    end

    // Hours registers keep only the 24 h tens bits.
    always_comb begin
        hi = lectura[7:4];
        lo = lectura[3:0];
        if (indice == 4'd2 || indice == 4'd10)
            hi = {2'b00, lectura[5:4]};
        valor = {4'd0, hi} * 8'd10 + {4'd0, lo};
        if (hi > 4'd9 || lo > 4'd9)
            valor = 8'hFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= REPOSO;
        else        estado <= estadoSig;
    end

    always_comb begin
        estadoSig = estado;
        unique case (estado)
            REPOSO:  if (iniciar) estadoSig = ESC_DIR;
            ESC_DIR: if (ultimaFase) estadoSig = PAUSA1;
            PAUSA1:  estadoSig = LEE;
            LEE:     if (ultimaFase) estadoSig = EMITE;
            EMITE:   estadoSig = PAUSA2;
            PAUSA2:  estadoSig = ultimoIndice ? REPOSO : ESC_DIR;
            default: estadoSig = REPOSO;
        endcase
    end

    always_comb begin
        rtc.cs_n    = !(estado == ESC_DIR || estado == LEE);
        rtc.wr_n    = (estado != ESC_DIR);
        rtc.rd_n    = (estado != LEE);
        rtc.ad_oe   = (estado == ESC_DIR);
        rtc.a_d     = (estado == LEE);
        rtc.ad_out  = (estado == ESC_DIR) ? dir : 8'h00;
        rtc.ocupado = (estado != REPOSO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            indice  <= '0;
            conTemp <= 1'b0;
            lectura <= '0;
        end else begin
            if (estadoSig != estado)
                cnt <= '0;
            else if (estado == ESC_DIR || estado == LEE)
                cnt <= cnt + 4'd1;
            if (estado == REPOSO && iniciar) begin
                conTemp <= temporizador;
                indice  <= '0;
            end
            if (estado == PAUSA2)
                indice <= indice + 4'd1;
            if (estado == LEE && ultimaFase)
                lectura <= rtc.ad_in;
        end
    end

    // Stream outputs are registered off the EMITE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rtc.datoRTC         <= '0;
            rtc.datoValido      <= 1'b0;
            rtc.inicioSecuencia <= 1'b0;
            rtc.finSecuencia    <= 1'b0;
        end else begin
            rtc.datoValido      <= (estado == EMITE);
            rtc.inicioSecuencia <= (estado == EMITE) && (indice == 4'd0);
            rtc.finSecuencia    <= (estado == EMITE) && ultimoIndice;
            if (estado == EMITE)
                rtc.datoRTC <= valor;
        end
    end
endmodule

// File: tb/tb_rtc_lector_secuencia.sv
// Randomized scoreboard bench for the RTC sequence reader,
// with an RTC register-file model on the multiplexed bus.
module tb_rtc_lector_secuencia;
    localparam int TF  = 2;
    localparam int PER = 2 * TF + 3;

    typedef struct packed {
        logic [7:0] d;
        logic       ini;
        logic       fin;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0;
    logic temporizador = 1'b0;

    rtc_lector_secuencia_if bus ();

    rtc_lector_secuencia #(
        .T_FASE(TF),
        .DIR_BASE_RELOJ(8'h21),
        .DIR_BASE_TEMP(8'h41)
    ) dut (
        .clk(clk),
        .reset(reset),
        .iniciar(iniciar),
        .temporizador(temporizador),
        .rtc(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] addrLatch;

    always @(posedge clk or negedge reset)
        if (!reset) addrLatch <= 8'h00;
        else if (!bus.cs_n && !bus.wr_n) addrLatch <= bus.ad_out;

    assign bus.ad_in = mem[addrLatch];

    exp_t       expQ[$];
    logic [7:0] addrQ[$];
    int nChk = 0;
    int nFail = 0;
    int cyc = 0;
    int startCyc = 0;
    int lastV = 0;
    int finCyc = -10;
    int bytesSeen = 0;
    bit prevWr = 1'b1;
    exp_t eM;
    logic [7:0] aM;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name,
                       input int act, input int req);
        nChk++;
        if (!ok) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    // Reference: BCD -> binary, hours keep two tens bits.
    function automatic logic [7:0] bcd(input logic [7:0] v,
                                       input bit hora);
        int hi, lo;
        hi = v / 16;
        lo = v % 16;
        if (hora) hi = hi % 4;
        if (hi > 9 || lo > 9) return 8'hFF;
        return 8'(hi * 10 + lo);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk(!(!bus.wr_n && !bus.rd_n), "strobes_exclusive",
                {bus.wr_n, bus.rd_n}, 3);
            chk(!bus.ad_oe || !bus.wr_n, "ad_oe_with_wr",
                bus.ad_oe, 0);
            chk(!(bus.wr_n && bus.rd_n) || bus.cs_n, "cs_idle",
                bus.cs_n, 1);
            if (prevWr && !bus.wr_n) begin
                if (addrQ.size() == 0) begin
                    chk(1'b0, "unexpected_addr", bus.ad_out, 0);
                end else begin
                    aM = addrQ.pop_front();
                    chk(bus.ad_out == aM, "addr", bus.ad_out, aM);
                end
            end
            if (bus.datoValido) begin
                bytesSeen++;
                if (expQ.size() == 0) begin
                    chk(1'b0, "unexpected_byte", bus.datoRTC, 0);
                end else begin
                    eM = expQ.pop_front();
                    chk(bus.datoRTC == eM.d, "datoRTC",
                        bus.datoRTC, eM.d);
                    chk(bus.inicioSecuencia == eM.ini, "inicio",
                        bus.inicioSecuencia, eM.ini);
                    chk(bus.finSecuencia == eM.fin, "fin",
                        bus.finSecuencia, eM.fin);
                    if (eM.ini)
                        chk(cyc - startCyc == PER, "first_latency",
                            cyc - startCyc, PER);
                    else
                        chk(cyc - lastV == PER, "spacing",
                            cyc - lastV, PER);
                    if (eM.fin) begin
                        chk(bus.ocupado, "ocupado_at_fin",
                            bus.ocupado, 1);
                        finCyc = cyc;
                    end
                end
                lastV = cyc;
            end
            if (cyc == finCyc + 1)
                chk(!bus.ocupado, "ocupado_falls", bus.ocupado, 0);
        end
        prevWr = bus.wr_n;
    end

    task automatic waitIdle();
        for (int k = 0; k < 600 && bus.ocupado; k++)
            @(negedge clk);
        chk(!bus.ocupado, "idle_timeout", bus.ocupado, 0);
    endtask

    task automatic startSeq(input bit t);
        int n;
        logic [7:0] a;
        exp_t e;
        waitIdle();
        n = t ? 11 : 8;
        for (int i = 0; i < n; i++) begin
            a = (i < 8) ? 8'(8'h21 + i) : 8'(8'h41 + i - 8);
            addrQ.push_back(a);
            e.d   = bcd(mem[a], (i == 2) || (i == 10));
            e.ini = (i == 0);
            e.fin = (i == n - 1);
            expQ.push_back(e);
        end
        temporizador = t;
        iniciar = 1'b1;
        startCyc = cyc;
        @(negedge clk);
        iniciar = 1'b0;
        temporizador = 1'($urandom);
    endtask

    task automatic waitDone();
        for (int k = 0; k < 1000 && (expQ.size() != 0 || bus.ocupado); k++)
            @(negedge clk);
        chk(expQ.size() == 0, "seq_timeout", expQ.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    task automatic waitBytes(input int target);
        for (int k = 0; k < 500 && bytesSeen < target; k++)
            @(negedge clk);
        chk(bytesSeen >= target, "byte_wait", bytesSeen, target);
    endtask

    task automatic randMem();
        for (int i = 0; i < 11; i++) begin
            int a;
            a = (i < 8) ? 8'h21 + i : 8'h41 + i - 8;
            if ($urandom_range(0, 7) == 0)
                mem[a] = 8'($urandom);
            else
                mem[a] = {4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9))};
        end
    endtask

    initial begin
        int base;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #2 reset = 1'b0;
        #1;
        chk(bus.cs_n && bus.wr_n && bus.rd_n, "reset_strobes",
            {bus.cs_n, bus.wr_n, bus.rd_n}, 7);
        chk(!bus.ad_oe && !bus.a_d && bus.ad_out == 8'h00, "reset_bus",
            {bus.ad_oe, bus.a_d, bus.ad_out}, 0);
        chk(bus.datoRTC == 8'h00 && !bus.datoValido && !bus.ocupado,
            "reset_stream", {bus.datoRTC, bus.datoValido, bus.ocupado}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        randMem();
        mem[8'h21] = 8'h59;
        startSeq(1'b0);
        waitDone();

        randMem();
        mem[8'h23] = 8'hE7;
        mem[8'h24] = 8'h3A;
        mem[8'h43] = 8'h23;
        startSeq(1'b1);
        waitDone();

        randMem();
        base = bytesSeen;
        startSeq(1'b0);
        waitBytes(base + 2);
        repeat (3) @(negedge clk);
        iniciar = 1'b1;
        temporizador = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        waitDone();
        repeat (30) @(negedge clk);
        randMem();
        startSeq(1'b0);
        waitDone();

        for (int r = 0; r < 6; r++) begin
            randMem();
            startSeq(1'($urandom));
            waitDone();
        end

        randMem();
        base = bytesSeen;
        startSeq(1'b0);
        waitBytes(base + 4);
        for (int k = 0; k < 50 && bus.rd_n; k++) @(negedge clk);
        chk(!bus.rd_n, "lee_wait", bus.rd_n, 0);
        #2 reset = 1'b0;
        #1;
        chk(bus.cs_n && bus.wr_n && bus.rd_n && !bus.ad_oe,
            "async_abort", {bus.cs_n, bus.wr_n, bus.rd_n, bus.ad_oe}, 14);
        chk(!bus.ocupado && !bus.datoValido, "abort_stream",
            {bus.ocupado, bus.datoValido}, 0);
        expQ.delete();
        addrQ.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk(!bus.ocupado, "idle_after_reset", bus.ocupado, 0);
        randMem();
        startSeq(1'b1);
        waitDone();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChk, nFail);
        $finish;
    end
endmodule
